conv_window_gen: RTL and testbench
==================================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter IMAGE_WIDTH, default 12, pixels per image row.
REQ-002 Parameter IMAGE_HEIGHT, default 12, rows per image.
REQ-003 Parameter KERNEL_SIZE, default 3, window edge K.
REQ-004 Parameter STRIDE, default 1, window step in both dimensions; legal range 1..KERNEL_SIZE.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_cnn  in  1  reset, synchronous, active-high.
REQ-007 pixel_in  in  1  binary pixel, raster order (row-major, top-left first).
REQ-008 pixel_valid  in  1  pixel_in is valid.
REQ-009 pixel_ready  out  1  block accepts a pixel this cycle.
REQ-010 window_out  out  K*K  window, bit i*K+j = pixel (row0+i, col0+j), same flattening as feature weights.
REQ-011 window_valid  out  1  window_out, window_row and window_col are valid.
REQ-012 window_ready  in  1  downstream consumes the window.
REQ-013 window_row, window_col  out  $clog2(IMAGE_HEIGHT), $clog2(IMAGE_WIDTH)  top-left coordinates (row0, col0) of the window.
REQ-014 frame_done  out  1  one-cycle pulse when the last window of a frame is consumed.

Function
REQ-015 A pixel transfers when pixel_valid and pixel_ready are both 1 on a clock edge; a window transfers when window_valid and window_ready are both 1.
REQ-016 Storage: K rows x IMAGE_WIDTH bits, circular by row (row r held in slot r mod K).
REQ-017 Column counter 0..IMAGE_WIDTH-1 and row counter 0..IMAGE_HEIGHT-1 advance on each pixel transfer; column wraps to 0 and increments row.
REQ-018 When pixel (r,c) transfers with r>=K-1, c>=K-1, (r-K+1) mod STRIDE==0 and (c-K+1) mod STRIDE==0, the window with top-left (r-K+1, c-K+1), including that pixel, is registered; window_valid goes to 1 the next cycle (latency 1).
REQ-019 No padding: windows per frame = ((H-K)/STRIDE+1)*((W-K)/STRIDE+1); 100 for the defaults.
REQ-020 pixel_ready = 0 in DONE; otherwise pixel_ready = !window_valid || window_ready.
REQ-021 If a window transfers and a new window is produced in the same cycle, the output register reloads, giving full throughput of one pixel per cycle.
REQ-022 While window_valid=1 and window_ready=0, window_out, window_row and window_col are held stable.
REQ-023 States and transitions:
- FILL: row < K-1.
- FILL -> RUN when pixel (K-2, W-1) transfers.
- RUN -> DONE when pixel (H-1, W-1) transfers.
- DONE -> FILL once the last window has transferred; frame_done = 1 in that cycle only.
REQ-024 Counters reset to 0 on entry to FILL. Stale storage is never emitted, because rows 0..K-2 of the new frame are rewritten before any window is formed.
REQ-025 window_valid is never asserted in FILL.

Reset
REQ-026 While rst_cnn=1 at a clock edge:
- state = FILL; counters = 0.
- window_valid = 0, frame_done = 0, window_out = 0, window_row = 0, window_col = 0.
REQ-027 Pixel storage is not cleared by reset.
REQ-028 Reset mid-frame discards any partial frame and any pending window; the next pixel accepted is treated as (0,0).
REQ-029 pixel_ready = 1 in the cycle after reset deasserts.

Structure
REQ-030 State typedef (FILL, RUN, DONE) and default geometry constants belong in shared package cnn_pkg.
REQ-031 Row storage and its circular slot indexing are implemented as sub-module conv_line_buffer; control and the output register stay in conv_window_gen.

Verification
REQ-032 Default parameters; 144 all-ones pixels with window_ready=1 -> exactly 100 windows, each window_out = 9'h1FF; first window_valid the cycle after pixel (2,2) transfers; exactly one frame_done pulse.
REQ-033 Single 1 at (5,5), zeros elsewhere -> exactly 9 nonzero windows (row0, col0 in 3..5), each with only bit (5-row0)*3+(5-col0) set.
REQ-034 Hold window_ready=0 for 5 cycles while window_valid=1 -> window_out, window_row and window_col stable; pixel_ready=0; still 100 windows total with no pixel lost.
REQ-035 STRIDE=2 instance, all-ones image -> 25 windows at coordinates (0,0), (0,2) ... (8,8), in raster order.
REQ-036 Assert rst_cnn after 50 pixels, then stream a full frame -> window_valid=0 the cycle after reset; first window after the 27th pixel (2,2) transfers; 100 windows.
REQ-037 Two back-to-back frames (checkerboard, then inverse) -> 200 windows, each matching the reference model, and two frame_done pulses.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and default geometry for the binary CNN window generator.
package cnn_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } win_state_e;

  localparam int unsigned DEF_IMAGE_WIDTH  = 12;
  localparam int unsigned DEF_IMAGE_HEIGHT = 12;
  localparam int unsigned DEF_KERNEL_SIZE  = 3;
  localparam int unsigned DEF_STRIDE       = 1;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-row circular line store; assembles the KxK window ending at the incoming pixel.
module conv_line_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE
) (
  input  logic                               clk,
  input  logic                               rst_cnn,
  input  logic                               wr_en,
  input  logic [$clog2(IMAGE_WIDTH)-1:0]     wr_col,
  input  logic                               row_end,
  input  logic                               frame_end,
  input  logic                               pixel,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0] window_c
);

  localparam int unsigned COL_W  = $clog2(IMAGE_WIDTH);
  localparam int unsigned SLOT_W = idx_width(KERNEL_SIZE);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(KERNEL_SIZE - 1);

  logic [IMAGE_WIDTH-1:0] rows_q [KERNEL_SIZE];
  logic [SLOT_W-1:0]      slot_q;
  int                     rd_slot;
  int                     rd_col;

  // Slot of the row currently being written; restarts at 0 with every frame.
  always_ff @(posedge clk) begin
    if (rst_cnn) begin
      slot_q <= '0;
    end else if (wr_en && row_end) begin
      if (frame_end || (slot_q == SLOT_LAST)) begin
        slot_q <= '0;
      end else begin
        slot_q <= slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      rows_q[slot_q][wr_col] <= pixel;
    end
  end

  // Oldest row lives one slot past the current one; newest bit bypasses storage.
  always_comb begin
    window_c = '0;
    rd_slot  = 0;
    rd_col   = 0;
    for (int i = 0; i < int'(KERNEL_SIZE); i++) begin
      for (int j = 0; j < int'(KERNEL_SIZE); j++) begin
        rd_slot = (int'(slot_q) + 1 + i) % int'(KERNEL_SIZE);
        rd_col  = int'(wr_col) + j - int'(KERNEL_SIZE) + 1;
        if ((i == int'(KERNEL_SIZE) - 1) && (j == int'(KERNEL_SIZE) - 1)) begin
          window_c[i*int'(KERNEL_SIZE) + j] = pixel;
        end else if ((rd_col >= 0) && (rd_col < int'(IMAGE_WIDTH))) begin
          window_c[i*int'(KERNEL_SIZE) + j] = rows_q[SLOT_W'(rd_slot)][COL_W'(rd_col)];
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streams a raster binary image and emits KxK sliding windows with valid/ready handshakes.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int unsigned KERNEL_SIZE  = DEF_KERNEL_SIZE,
  parameter int unsigned STRIDE       = DEF_STRIDE
) (
  input  logic                               clk,
  input  logic                               rst_cnn,
  input  logic                               pixel_in,
  input  logic                               pixel_valid,
  output logic                               pixel_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0] window_out,
  output logic                               window_valid,
  input  logic                               window_ready,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]    window_row,
  output logic [$clog2(IMAGE_WIDTH)-1:0]     window_col,
  output logic                               frame_done
);

  localparam int unsigned ROW_W = $clog2(IMAGE_HEIGHT);
  localparam int unsigned COL_W = $clog2(IMAGE_WIDTH);
  localparam int unsigned WIN_W = KERNEL_SIZE * KERNEL_SIZE;

  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(KERNEL_SIZE - 2);
  localparam logic [ROW_W-1:0] ROW_STRIDE    = ROW_W'(STRIDE);
  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(KERNEL_SIZE - 1);
  localparam logic [COL_W-1:0] COL_STRIDE    = COL_W'(STRIDE);

  win_state_e       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             frame_done_d;
  logic [WIN_W-1:0] window_c;
  logic             out_free;
  logic             pix_xfer;
  logic             win_xfer;
  logic             last_col;
  logic             last_row;
  logic             win_hit;

  assign out_free    = !window_valid || window_ready;
  assign pixel_ready = (state_q != DONE) && out_free;
  assign pix_xfer    = pixel_valid && pixel_ready;
  assign win_xfer    = window_valid && window_ready;
  assign last_col    = (col_q == COL_LAST);
  assign last_row    = (row_q == ROW_LAST);

  // Window completes when the pixel lands on a stride-aligned bottom-right corner.
  assign win_hit = pix_xfer
                && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN)
                && (((row_q - ROW_FIRST_WIN) % ROW_STRIDE) == '0)
                && (((col_q - COL_FIRST_WIN) % COL_STRIDE) == '0);

  conv_line_buffer #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_line_buffer (
    .clk       (clk),
    .rst_cnn   (rst_cnn),
    .wr_en     (pix_xfer),
    .wr_col    (col_q),
    .row_end   (last_col),
    .frame_end (last_row),
    .pixel     (pixel_in),
    .window_c  (window_c)
  );

  always_ff @(posedge clk) begin
    if (rst_cnn) begin
      state_q    <= FILL;
      row_q      <= '0;
      col_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;

    if (pix_xfer) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      FILL: begin
        if (pix_xfer && last_col && (row_q == ROW_FILL_LAST)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pix_xfer && last_col && last_row) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Leave once the output register is empty or draining this cycle.
        if (out_free) begin
          state_d      = FILL;
          row_d        = '0;
          col_d        = '0;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Output register reloads on the same edge it drains, sustaining one pixel per cycle.
  always_ff @(posedge clk) begin
    if (rst_cnn) begin
      window_valid <= 1'b0;
      window_out   <= '0;
      window_row   <= '0;
      window_col   <= '0;
    end else if (win_hit) begin
      window_valid <= 1'b1;
      window_out   <= window_c;
      window_row   <= row_q - ROW_FIRST_WIN;
      window_col   <= col_q - COL_FIRST_WIN;
    end else if (win_xfer) begin
      window_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: stride-1 and stride-2 instances against a pixel-array model.
module tb_conv_window_gen;

  localparam int W    = 12;
  localparam int H    = 12;
  localparam int K    = 3;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [8:0] d;
    logic [3:0] r;
    logic [3:0] c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_cnn;
  logic       a_pin, a_pv, a_prdy, a_wv, a_wr, a_fd;
  logic [8:0] a_win;
  logic [3:0] a_row, a_col;
  logic       b_pin, b_pv, b_prdy, b_wv, b_wr, b_fd;
  logic [8:0] b_win;
  logic [3:0] b_row, b_col;

  conv_window_gen dut_s1 (
    .clk          (clk),
    .rst_cnn      (rst_cnn),
    .pixel_in     (a_pin),
    .pixel_valid  (a_pv),
    .pixel_ready  (a_prdy),
    .window_out   (a_win),
    .window_valid (a_wv),
    .window_ready (a_wr),
    .window_row   (a_row),
    .window_col   (a_col),
    .frame_done   (a_fd)
  );

  conv_window_gen #(.STRIDE(2)) dut_s2 (
    .clk          (clk),
    .rst_cnn      (rst_cnn),
    .pixel_in     (b_pin),
    .pixel_valid  (b_pv),
    .pixel_ready  (b_prdy),
    .window_out   (b_win),
    .window_valid (b_wv),
    .window_ready (b_wr),
    .window_row   (b_row),
    .window_col   (b_col),
    .frame_done   (b_fd)
  );

  logic img [0:2*NPIX-1];
  exp_t exp_q [$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic drive(input int sel, input logic pv, input logic pin, input logic wr);
    if (sel == 0) begin
      a_pv = pv; a_pin = pin; a_wr = wr;
    end else begin
      b_pv = pv; b_pin = pin; b_wr = wr;
    end
  endtask

  task automatic observe(input int sel, output logic pr, output logic wv, output logic fd,
                         output logic [8:0] wd, output logic [3:0] wrow, output logic [3:0] wcol);
    if (sel == 0) begin
      pr = a_prdy; wv = a_wv; fd = a_fd; wd = a_win; wrow = a_row; wcol = a_col;
    end else begin
      pr = b_prdy; wv = b_wv; fd = b_fd; wd = b_win; wrow = b_row; wcol = b_col;
    end
  endtask

  // Reference: build the expected window straight from the image array.
  function automatic void model_pixel(input int idx, input int stride);
    int   fb, p, r, c;
    exp_t e;
    fb = (idx / NPIX) * NPIX;
    p  = idx % NPIX;
    r  = p / W;
    c  = p % W;
    if (r >= K-1 && c >= K-1 && ((r-K+1) % stride) == 0 && ((c-K+1) % stride) == 0) begin
      e.r = 4'(r-K+1);
      e.c = 4'(c-K+1);
      e.d = '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          e.d[i*K+j] = img[fb + (r-K+1+i)*W + (c-K+1+j)];
      exp_q.push_back(e);
    end
  endfunction

  task automatic run_stream(input int sel, input int stride, input int npix, input int stall_at,
                            output int nwin, output int nnz, output int ndone, output int lat);
    int         idx, cyc, pix_cyc, hold;
    bit         seen, stalled, in_stall;
    logic       cur_v, cur_r;
    logic       pr, wv, fd;
    logic [8:0] wd;
    logic [3:0] wrow, wcol;
    exp_t       held, e;
    idx = 0; cyc = 0; pix_cyc = -1; hold = 0;
    seen = 0; stalled = 0; in_stall = 0;
    nwin = 0; nnz = 0; ndone = 0; lat = -1;
    held = '0;
    cur_v = 1'b1; cur_r = 1'b1;
    drive(sel, cur_v, img[0], cur_r);
    while (cyc < 3000 && (idx < npix || exp_q.size() != 0 || ndone < npix / NPIX)) begin
      @(negedge clk);
      observe(sel, pr, wv, fd, wd, wrow, wcol);
      if (fd) ndone++;
      if (wv && !seen) begin
        seen = 1;
        if (pix_cyc >= 0) lat = cyc - pix_cyc;
      end
      if (in_stall) begin
        compared++;
        if ({wd, wrow, wcol} !== {held.d, held.r, held.c}) begin
          mismatched++;
          $display("FAIL stall_hold: got %h (%0d,%0d) want %h (%0d,%0d)",
                   wd, wrow, wcol, held.d, held.r, held.c);
        end
        compared++;
        if (pr !== 1'b0) begin
          mismatched++;
          $display("FAIL stall_pixel_ready: got %b want 0", pr);
        end
      end
      if (wv && cur_r) begin
        nwin++;
        if (wd != 9'd0) nnz++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL window_extra: got %h (%0d,%0d) want none", wd, wrow, wcol);
        end else begin
          e = exp_q.pop_front();
          if ({wd, wrow, wcol} !== {e.d, e.r, e.c}) begin
            mismatched++;
            $display("FAIL window_%0d: got %h (%0d,%0d) want %h (%0d,%0d)",
                     nwin, wd, wrow, wcol, e.d, e.r, e.c);
          end
        end
      end
      if (cur_v && pr) begin
        model_pixel(idx, stride);
        if ((idx % NPIX) == 2*W+2 && pix_cyc < 0) pix_cyc = cyc;
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
      observe(sel, pr, wv, fd, wd, wrow, wcol);
      in_stall = 0;
      if (!stalled && stall_at >= 0 && wv && nwin == stall_at) begin
        stalled = 1;
        hold = 5;
        held.d = wd; held.r = wrow; held.c = wcol;
      end
      if (hold > 0) begin
        hold--;
        cur_r = 1'b0;
        in_stall = 1;
      end else begin
        cur_r = 1'b1;
      end
      cur_v = (idx < npix);
      drive(sel, cur_v, cur_v ? img[idx] : 1'b0, cur_r);
    end
    compared++;
    if (cyc >= 3000) begin
      mismatched++;
      $display("FAIL stream_timeout: got %0d pixels %0d pending want %0d pixels 0 pending",
               idx, exp_q.size(), npix);
    end
    exp_q.delete();
    drive(sel, 1'b0, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      observe(sel, pr, wv, fd, wd, wrow, wcol);
      if (fd) ndone++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic       pr, wv, fd;
    logic [8:0] wd;
    logic [3:0] wrow, wcol;
    rst_cnn = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      observe(s, pr, wv, fd, wd, wrow, wcol);
      compared++;
      if ({wv, fd, wd, wrow, wcol} !== 19'd0) begin
        mismatched++;
        $display("FAIL reset_outputs_%0d: got v=%b fd=%b w=%h (%0d,%0d) want all 0",
                 s, wv, fd, wd, wrow, wcol);
      end
    end
    @(posedge clk); #1;
    rst_cnn = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      observe(s, pr, wv, fd, wd, wrow, wcol);
      compared++;
      if (pr !== 1'b1) begin
        mismatched++;
        $display("FAIL reset_pixel_ready_%0d: got %b want 1", s, pr);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_all_ones();
    int nwin, nnz, ndone, lat;
    for (int i = 0; i < NPIX; i++) img[i] = 1'b1;
    run_stream(0, 1, NPIX, -1, nwin, nnz, ndone, lat);
    check_int("ones_windows", nwin, 100);
    check_int("ones_frame_done", ndone, 1);
    check_int("ones_latency", lat, 1);
  endtask

  task automatic test_single_one();
    int nwin, nnz, ndone, lat;
    for (int i = 0; i < NPIX; i++) img[i] = 1'b0;
    img[5*W+5] = 1'b1;
    run_stream(0, 1, NPIX, -1, nwin, nnz, ndone, lat);
    check_int("single_windows", nwin, 100);
    check_int("single_nonzero", nnz, 9);
    check_int("single_frame_done", ndone, 1);
  endtask

  task automatic test_stall();
    int nwin, nnz, ndone, lat;
    for (int i = 0; i < NPIX; i++) img[i] = 1'($urandom_range(0, 1));
    run_stream(0, 1, NPIX, 10, nwin, nnz, ndone, lat);
    check_int("stall_windows", nwin, 100);
    check_int("stall_frame_done", ndone, 1);
  endtask

  task automatic test_stride2();
    int nwin, nnz, ndone, lat;
    for (int i = 0; i < NPIX; i++) img[i] = 1'b1;
    run_stream(1, 2, NPIX, -1, nwin, nnz, ndone, lat);
    check_int("stride2_windows", nwin, 25);
    check_int("stride2_frame_done", ndone, 1);
  endtask

  task automatic test_mid_reset();
    int         cnt, cyc, nwin, nnz, ndone, lat;
    logic       pr, wv, fd;
    logic [8:0] wd;
    logic [3:0] wrow, wcol;
    cnt = 0; cyc = 0;
    drive(0, 1'b1, 1'b1, 1'b1);
    while (cnt < 50 && cyc < 500) begin
      @(negedge clk);
      observe(0, pr, wv, fd, wd, wrow, wcol);
      if (pr) cnt++;
      @(posedge clk); #1;
      cyc++;
      if (cnt == 50) drive(0, 1'b0, 1'b0, 1'b1);
    end
    check_int("midreset_prefix_pixels", cnt, 50);
    rst_cnn = 1'b1;
    @(posedge clk); #1;
    rst_cnn = 1'b0;
    @(negedge clk);
    observe(0, pr, wv, fd, wd, wrow, wcol);
    compared++;
    if (wv !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_valid: got %b want 0", wv);
    end
    @(posedge clk); #1;
    for (int i = 0; i < NPIX; i++) img[i] = 1'($urandom_range(0, 1));
    run_stream(0, 1, NPIX, -1, nwin, nnz, ndone, lat);
    check_int("midreset_windows", nwin, 100);
    check_int("midreset_latency", lat, 1);
    check_int("midreset_frame_done", ndone, 1);
  endtask

  task automatic test_back_to_back();
    int nwin, nnz, ndone, lat;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[f*NPIX + r*W + c] = 1'(((r + c) & 1) ^ f);
    run_stream(0, 1, 2*NPIX, -1, nwin, nnz, ndone, lat);
    check_int("b2b_windows", nwin, 200);
    check_int("b2b_frame_done", ndone, 2);
  endtask

  initial begin
    rst_cnn = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_all_ones();
    test_single_one();
    test_stall();
    test_stride2();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
